// File: rtl/imem_loader.sv
// Bootstrap loader: receives a framed byte stream (header, data, checksum), writes
// assembled words into instruction memory and releases the CPU on a good checksum.
module imem_loader #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic                  mem_en,
  output logic [addWidth-1:0]   mem_addr,
  output logic [dataWidth-1:0]  mem_di,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [addWidth:0]     words_loaded
);

  localparam int BPW = dataWidth / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WLW = addWidth + 1;
  localparam logic [31:0] MAX_IDX = 32'((1 << addWidth) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t               state;
  logic [addWidth-1:0]  last_idx;
  logic [7:0]           chk;
  logic [CW-1:0]        byte_cnt;
  logic [dataWidth-1:0] word;
  logic [dataWidth-1:0] next_word;
  logic                 xfer;

  assign xfer      = rx_valid && rx_ready;
  // MSB byte arrives first, so each new byte enters at the bottom.
  assign next_word = (word << 8) | dataWidth'(rx_data);

  // Loader state machine; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      mem_di       <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      last_idx     <= '0;
      chk          <= 8'h00;
      byte_cnt     <= '0;
      word         <= '0;
    end else if (load_start) begin
      // Restart wins over any byte offered in the same cycle.
      state        <= S_HDR;
      rx_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_en       <= 1'b0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rx_ready <= 1'b0;
        end
        S_HDR: begin
          if (xfer) begin
            if (32'(rx_data) > MAX_IDX) begin
              state    <= S_ERR;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              state    <= S_DATA;
              last_idx <= addWidth'(rx_data);
              chk      <= rx_data;
              mem_addr <= '0;
              byte_cnt <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word <= next_word;
            chk  <= chk ^ rx_data;
            if (byte_cnt == CW'(BPW - 1)) begin
              state    <= S_WRITE;
              rx_ready <= 1'b0;
              mem_we   <= 1'b1;
              mem_en   <= 1'b1;
              mem_di   <= next_word;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        S_WRITE: begin
          mem_we       <= 1'b0;
          mem_en       <= 1'b0;
          rx_ready     <= 1'b1;
          words_loaded <= words_loaded + WLW'(1);
          if (mem_addr == last_idx) begin
            state <= S_CHK;
          end else begin
            mem_addr <= mem_addr + addWidth'(1);
            state    <= S_DATA;
          end
        end
        S_CHK: begin
          if (xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == chk) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          rx_ready <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
          mem_we   <= 1'b0;
          mem_en   <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are queued when a
// frame is built, and a negedge monitor pops them as the DUT pulses mem_we.
module tb_imem_loader;

  localparam int AW  = 6;
  localparam int DW  = 16;
  localparam int BPW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  imem_loader #(.addWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_en(mem_en), .mem_addr(mem_addr), .mem_di(mem_di),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int         vectors = 0;
  int         miscompares = 0;
  wr_t        exp_q[$];
  logic [7:0] payload[$];
  bit         in_frame = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest queued write.
  always @(negedge clk) begin
    wr_t e;
    if (in_frame) check("rx_ready_not_write", 64'(rx_ready), 64'(!mem_we));
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_di);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e.addr));
        check("write_data", 64'(mem_di), 64'(e.data));
        check("write_en", 64'(mem_en), 64'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: rx_ready %b, expected 1 within 50 cycles", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    in_frame   = 1'b1;
  endtask

  task automatic check_reset_values();
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_di", 64'(mem_di), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_words_loaded", 64'(words_loaded), 64'd0);
  endtask

  task automatic wait_end(input bit exp_done, input bit exp_err, input int exp_words);
    int n = 0;
    while (!(load_done === 1'b1 || load_err === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL end_timeout: done %b err %b after 200 cycles", load_done, load_err);
    end
    @(negedge clk);
    check("end_load_done", 64'(load_done), 64'(exp_done));
    check("end_load_err", 64'(load_err), 64'(exp_err));
    check("end_cpu_hold", 64'(cpu_hold), 64'(!exp_done));
    check("end_words_loaded", 64'(words_loaded), 64'(exp_words));
    check("end_rx_ready", 64'(rx_ready), 64'd0);
    check("end_pending_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // mode 0: correct checksum, 1: send chk_in as given, 2: corrupt checksum.
  task automatic run_frame(input int hdr, input int gmin, input int gmax,
                           input int mode, input logic [7:0] chk_in);
    logic [7:0] chk;
    logic [7:0] sent;
    wr_t        w;
    pulse_start();
    if (hdr <= (1 << AW) - 1) begin
      for (int i = 0; i <= hdr; i++) begin
        w.addr = AW'(i);
        w.data = '0;
        for (int b = 0; b < BPW; b++) w.data = (w.data << 8) | DW'(payload[i*BPW + b]);
        exp_q.push_back(w);
      end
    end
    send_byte(8'(hdr), $urandom_range(gmax, gmin));
    if (hdr > (1 << AW) - 1) begin
      in_frame = 1'b0;
      wait_end(1'b0, 1'b1, 0);
      return;
    end
    chk = 8'(hdr);
    for (int j = 0; j < BPW * (hdr + 1); j++) begin
      chk = chk ^ payload[j];
      send_byte(payload[j], $urandom_range(gmax, gmin));
    end
    sent = (mode == 0) ? chk : (mode == 1) ? chk_in : (chk ^ 8'h5A);
    send_byte(sent, $urandom_range(gmax, gmin));
    in_frame = 1'b0;
    wait_end(sent == chk, sent != chk, hdr + 1);
  endtask

  task automatic fill_payload(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    int hdr;
    rst        = 1'b1;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // Reference 2-word frame, good then bad checksum.
    payload = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame(1, 0, 0, 1, 8'h41);
    run_frame(1, 0, 0, 1, 8'h42);

    // Header out of range, then the largest legal frame.
    payload.delete();
    run_frame(8'h40, 0, 0, 0, 8'h00);
    fill_payload(BPW * 64);
    run_frame(63, 0, 0, 0, 8'h00);

    // Same good frame with 3-cycle bubbles before every byte.
    payload = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame(1, 3, 3, 1, 8'h41);

    // Reset right after the first word is written.
    pulse_start();
    exp_q.push_back(wr_t'{addr: AW'(0), data: DW'(16'h1234)});
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    in_frame = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();
    check("rst_first_word_written", 64'(exp_q.size()), 64'd0);
    fill_payload(BPW * 2);
    run_frame(1, 0, 1, 0, 8'h00);

    // Restart in the middle of DATA, then a full 1-word frame.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    payload = '{8'hBE, 8'hEF};
    run_frame(0, 0, 0, 1, 8'h51);

    // Random frames: lengths, bubbles, bad headers and corrupted checksums.
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(9, 0) == 0) hdr = int'($urandom_range(255, 64));
      else hdr = int'($urandom_range(5, 0));
      if (hdr < 64) fill_payload(BPW * (hdr + 1));
      else payload.delete();
      run_frame(hdr, 0, 2, ($urandom_range(3, 0) == 0) ? 2 : 0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
